regfile_scan: RTL and testbench

Parametrised integer register file for the `cpu` core. It replaces the fixed 32×32 register array and its hard-wired `led` tap on `r1` with configurable width, depth and read-port count. A built-in scan engine steps the low bits of every register onto the board LEDs, so any register can be checked on hardware without a simulator. It sits between decode (read addresses), writeback (write port) and the top-level `led` pins.

---
 rtl/regfile_scan.sv | 149 ++++++++++++++
 tb/tb_regfile_scan.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : regfile_scan
//  Purpose  : Parametrised integer register file for the cpu core. It has
//             combinational multi-port reads and a single write port, and
//             register 0 is hard-wired to zero. A scan engine steps the low
//             LED_WIDTH bits of registers 1..2^ADDR_WIDTH-1 onto the board
//             LEDs, holding each register for SCAN_PERIOD cycles. Outside a
//             scan the LEDs show register SHOW_REG.
//  Ports    : clock        - rising-edge clock
//             reset_n      - asynchronous active-low reset
//             rd_addr      - packed read addresses, port p at [p*AW +: AW]
//             rd_data      - packed read data,     port p at [p*DW +: DW]
//             wr_en        - write enable
//             wr_addr      - write address (writes to 0 are discarded)
//             wr_data      - write data
//             scan_start   - one-cycle scan request (ignored while busy)
//             scan_busy    - high while a scan is running
//             led          - active-high LED value
//  Options  : REGFILE_BYPASS_EN - when defined, a read port whose address
//             matches an active non-zero write returns wr_data in the same
//             cycle. The LED path is never bypassed.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_scan #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int READ_PORTS  = 2,
    parameter int LED_WIDTH   = 6,
    parameter int SHOW_REG    = 1,
    parameter int SCAN_PERIOD = 4
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [READ_PORTS*DATA_WIDTH-1:0] rd_data,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             scan_start,
    output logic                             scan_busy,
    output logic [LED_WIDTH-1:0]             led
);

    localparam int c_depth = 1 << ADDR_WIDTH;
    localparam int c_cnt_w = $clog2(SCAN_PERIOD) + 1;

    localparam logic [ADDR_WIDTH-1:0] c_first_idx = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_last_idx  = ADDR_WIDTH'(c_depth - 1);
    localparam logic [ADDR_WIDTH-1:0] c_show_addr = ADDR_WIDTH'(SHOW_REG);
    localparam logic [c_cnt_w-1:0]    c_last_cnt  = c_cnt_w'(SCAN_PERIOD - 1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_scan = 1'b1;

    // ------------------------------------------------------------------------
    // Register storage. Entry 0 is cleared by reset and never written, so it
    // always reads as zero without any extra read-side muxing.
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_regs [c_depth];
    logic                  w_wr_valid;

    assign w_wr_valid = wr_en && (wr_addr != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < c_depth; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_valid) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // Read ports: independent combinational lookups.
    // ------------------------------------------------------------------------
    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd_port
        logic [ADDR_WIDTH-1:0] w_addr;
        assign w_addr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef REGFILE_BYPASS_EN
        // reset_n gates the bypass so every port reads zero during reset,
        // even if a write is being presented at the same time.
        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] =
            (reset_n && w_wr_valid && (wr_addr == w_addr)) ? wr_data : r_regs[w_addr];
`else
        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = r_regs[w_addr];
`endif
    end

    // ------------------------------------------------------------------------
    // Scan FSM. r_index walks 1..depth-1 and never wraps to 0; r_count
    // holds each register on the LEDs for SCAN_PERIOD cycles.
    // ------------------------------------------------------------------------
    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [c_cnt_w-1:0]    r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
            r_index <= c_first_idx;
            r_count <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (scan_start) begin
                        r_state <= c_st_scan;
                        r_index <= c_first_idx;
                        r_count <= '0;
                    end
                end
                c_st_scan: begin
                    if (r_count == c_last_cnt) begin
                        r_count <= '0;
                        if (r_index == c_last_idx) begin
                            // Finished the last register; a start request on
                            // this same edge is deliberately not honoured.
                            r_state <= c_st_idle;
                            r_index <= c_first_idx;
                        end else begin
                            r_index <= r_index + c_first_idx;
                        end
                    end else begin
                        r_count <= r_count + c_cnt_w'(1);
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_index <= c_first_idx;
                    r_count <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // LED output reads stored contents only, so a write shows up on the LEDs
    // in the cycle after its edge regardless of bypass.
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_led_addr;

    assign scan_busy  = (r_state == c_st_scan);
    assign w_led_addr = scan_busy ? r_index : c_show_addr;
    assign led        = r_regs[w_led_addr][LED_WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_regfile_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_scan
//  Purpose  : Directed self-checking bench for regfile_scan with default
//             parameters (32x32, two read ports, 6 LEDs, SCAN_PERIOD=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scan;

    localparam int DW = 32;
    localparam int AW = 5;

    logic            clock;
    logic            reset_n;
    logic [2*AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_data;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            scan_start;
    logic            scan_busy;
    logic [5:0]      led;

    int n_checks = 0;
    int n_errors = 0;

    regfile_scan dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .scan_start (scan_start),
        .scan_busy  (scan_busy),
        .led        (led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clock);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clock);
        #1;
        wr_en   = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic pulse_start();
        @(negedge clock);
        scan_start = 1'b1;
        @(posedge clock);
        #1;
        scan_start = 1'b0;
    endtask

    int busy_cycles;
    int exp_led;

    initial begin
        reset_n    = 1'b0;
        rd_addr    = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        scan_start = 1'b0;

        // Reset state
        #3;
        chk("reset_rd_data", rd_data, 64'd0);
        chk("reset_led", {58'd0, led}, 64'd0);
        chk("reset_busy", {63'd0, scan_busy}, 64'd0);
        #10 reset_n = 1'b1;

        // Arbitrary writes, then asynchronous reset between edges
        do_write(5'd3, 32'h0000_00AA);
        do_write(5'd1, 32'h0000_003F);
        set_rd(5'd1, 5'd3);
        #1;
        chk("pre_reset_x1", {32'd0, rd_data[31:0]}, 64'h3F);
        chk("pre_reset_led", {58'd0, led}, 64'h3F);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_x1", {32'd0, rd_data[31:0]}, 64'd0);
        chk("async_reset_x3", {32'd0, rd_data[63:32]}, 64'd0);
        chk("async_reset_led", {58'd0, led}, 64'd0);
        #3 reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("post_reset_x3", {32'd0, rd_data[63:32]}, 64'd0);
        chk("post_reset_led", {58'd0, led}, 64'd0);

        // Write/read: x1=15, port0 reads x1, port1 reads x2
        set_rd(5'd1, 5'd2);
        do_write(5'd1, 32'd15);
        chk("wr_x1_p0", {32'd0, rd_data[31:0]}, 64'd15);
        chk("wr_x1_p1_x2", {32'd0, rd_data[63:32]}, 64'd0);
        chk("wr_x1_led", {58'd0, led}, 64'd15);

        // x0 writes are discarded and never bypassed
        set_rd(5'd0, 5'd0);
        @(negedge clock);
        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_data = 32'hDEAD_BEEF;
        #1;
        chk("x0_same_cycle", rd_data, 64'd0);
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        chk("x0_after_edge", rd_data, 64'd0);

        // Same-cycle write/read of x5
        @(negedge clock);
        set_rd(5'd5, 5'd1);
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'h1234;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_p0_before_edge", {32'd0, rd_data[31:0]}, 64'h1234);
`else
        chk("nobypass_p0_before_edge", {32'd0, rd_data[31:0]}, 64'd0);
`endif
        chk("bypass_p1_unrelated", {32'd0, rd_data[63:32]}, 64'd15);
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        chk("x5_after_edge", {32'd0, rd_data[31:0]}, 64'h1234);

        // Load x_i = i and run a scan
        for (int i = 1; i < 32; i++) begin
            do_write(AW'(i), DW'(i));
        end
        chk("idle_led_show_reg", {58'd0, led}, 64'd1);
        pulse_start();
        busy_cycles = 0;
        for (int c = 0; c < 130; c++) begin
            exp_led = (c < 124) ? (c / 4 + 1) : 1;
            if (scan_busy) busy_cycles++;
            chk($sformatf("scan_busy_c%0d", c), {63'd0, scan_busy}, (c < 124) ? 64'd1 : 64'd0);
            chk($sformatf("scan_led_c%0d", c), {58'd0, led}, 64'(exp_led));
            // Restart at cycle 50 is ignored; a start on the ending edge too.
            scan_start = (c == 50) || (c == 123);
            @(posedge clock);
            #1;
        end
        scan_start = 1'b0;
        chk("scan_busy_total", 64'(busy_cycles), 64'd124);

        // Reset in the middle of a scan
        set_rd(5'd5, 5'd31);
        pulse_start();
        repeat (19) @(posedge clock);
        #1;
        chk("midscan_busy", {63'd0, scan_busy}, 64'd1);
        chk("midscan_led", {58'd0, led}, 64'd5);
        #3 reset_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, scan_busy}, 64'd0);
        chk("abort_led", {58'd0, led}, 64'd0);
        chk("abort_rd_data", rd_data, 64'd0);
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("after_abort_busy", {63'd0, scan_busy}, 64'd0);
        chk("after_abort_led", {58'd0, led}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
